// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/serial_adder_cell.sv
// One-bit full adder built from two half adders and an OR gate; the per-bit
// datapath of the serial adder.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);
    logic partSum;
    logic carryAb;
    logic carryPc;

    half_adder u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (partSum),
        .carry (carryAb)
    );

    half_adder u_ha1 (
        .a     (partSum),
        .b     (cin),
        .sum   (sum),
        .carry (carryPc)
    );

    assign carry = carryAb | carryPc;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds a + b + cin one bit per clock, LSB first, and pulses
// done when sum/cout hold the complete result.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic             bitSum;
    logic             bitCarry;
    logic             lastBit;

    full_adder_cell u_fa (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .cin   (carry_q),
        .sum   (bitSum),
        .carry (bitCarry)
    );

    // New result bit enters from the MSB so the sum is aligned after WIDTH shifts.
    always_comb begin
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = bitSum;
    end

    assign lastBit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= bitCarry;
                    cnt_q   <= cnt_q + CW'(1);
                    if (lastBit) begin
                        cout_q  <= bitCarry;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances against
// a plain-arithmetic model of a + b + cin.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1;
    logic       a1;
    logic       b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic       sum1;
    logic       cout1;

    bit         sel;
    logic       curBusy;
    logic       curDone;
    logic [7:0] curSum;
    logic       curCout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    assign curBusy = sel ? busy1 : busy8;
    assign curDone = sel ? done1 : done8;
    assign curSum  = sel ? {7'b0, sum1} : sum8;
    assign curCout = sel ? cout1 : cout8;

    // Reference: the full (WIDTH+1)-bit arithmetic sum of the operands.
    function automatic logic [8:0] model8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        return {1'b0, av} + {1'b0, bv} + {8'b0, cv};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit useSmall, input logic [7:0] av, input logic [7:0] bv,
                                 input logic cv, input logic st);
        if (useSmall) begin
            a1     = av[0];
            b1     = bv[0];
            cin1   = cv;
            start1 = st;
        end else begin
            a8     = av;
            b8     = bv;
            cin8   = cv;
            start8 = st;
        end
    endtask

    // One full operation: start sampled on edge 0, done expected after edge w.
    task automatic runOp(input bit useSmall, input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input int rePulseAt, input string tag);
        int         w;
        int         doneAt;
        int         doneCnt;
        int         busyCnt;
        logic [8:0] tot;
        logic [7:0] expSum;
        logic       expCout;
        logic [7:0] gotSum;
        logic       gotCout;
        w       = useSmall ? 1 : 8;
        doneAt  = -1;
        doneCnt = 0;
        busyCnt = 0;
        gotSum  = 8'h00;
        gotCout = 1'b0;
        sel     = useSmall;
        tot     = model8(useSmall ? {7'b0, av[0]} : av, useSmall ? {7'b0, bv[0]} : bv, cv);
        expSum  = useSmall ? {7'b0, tot[0]} : tot[7:0];
        expCout = useSmall ? tot[1] : tot[8];
        applyStimulus(useSmall, av, bv, cv, 1'b1);
        tick;
        applyStimulus(useSmall, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        for (int k = 1; k <= w + 3; k++) begin
            if (curBusy) busyCnt++;
            if (curDone) begin
                doneCnt++;
                if (doneAt < 0) begin
                    doneAt  = k - 1;
                    gotSum  = curSum;
                    gotCout = curCout;
                end
            end
            if (k == rePulseAt)
                applyStimulus(useSmall, ~av, bv ^ 8'h5A, ~cv, 1'b1);
            else
                applyStimulus(useSmall, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            tick;
        end
        checkOutput({tag, "_doneAt"}, 32'(doneAt), 32'(w));
        checkOutput({tag, "_doneCnt"}, 32'(doneCnt), 32'd1);
        checkOutput({tag, "_busyCnt"}, 32'(busyCnt), 32'(w));
        checkOutput({tag, "_sum"}, {24'b0, gotSum}, {24'b0, expSum});
        checkOutput({tag, "_cout"}, {31'b0, gotCout}, {31'b0, expCout});
    endtask

    initial begin
        logic [7:0] opA [3];
        logic [7:0] opB [3];
        logic       opC [3];
        int         doneTimes [3];
        int         idx;
        bit         doneSeen;
        logic [8:0] tot;

        sel = 1'b0;
        rst_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        #3;
        checkOutput("rst_busy", {31'b0, busy8}, 32'd0);
        checkOutput("rst_done", {31'b0, done8}, 32'd0);
        checkOutput("rst_sum", {24'b0, sum8}, 32'd0);
        checkOutput("rst_cout", {31'b0, cout8}, 32'd0);
        tick;
        rst_n = 1'b1;
        tick;

        $display("[TB] directed operations, WIDTH=8");
        runOp(1'b0, 8'h0F, 8'h01, 1'b0, 0, "add0F01");
        runOp(1'b0, 8'hFF, 8'h01, 1'b0, 0, "addFF01");
        runOp(1'b0, 8'hFF, 8'hFF, 1'b1, 0, "addFFFFc");
        runOp(1'b0, 8'h5C, 8'hA7, 1'b1, 3, "repulse");

        $display("[TB] reset during RUN");
        sel = 1'b0;
        applyStimulus(1'b0, 8'hA5, 8'h3C, 1'b1, 1'b1);
        tick;
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick;
        tick;
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", {31'b0, busy8}, 32'd0);
        checkOutput("abort_done", {31'b0, done8}, 32'd0);
        checkOutput("abort_sum", {24'b0, sum8}, 32'd0);
        checkOutput("abort_cout", {31'b0, cout8}, 32'd0);
        doneSeen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k == 2) rst_n = 1'b1;
            tick;
            if (done8) doneSeen = 1'b1;
        end
        checkOutput("abort_nodone", {31'b0, doneSeen}, 32'd0);
        runOp(1'b0, 8'h12, 8'h34, 1'b0, 0, "after_rst");

        $display("[TB] random operations, WIDTH=8");
        for (int i = 0; i < 12; i++)
            runOp(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 0, "rand");

        $display("[TB] start held high");
        sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            opA[i]       = 8'($urandom);
            opB[i]       = 8'($urandom);
            opC[i]       = 1'($urandom);
            doneTimes[i] = 0;
        end
        idx = 0;
        applyStimulus(1'b0, opA[0], opB[0], opC[0], 1'b1);
        for (int c = 0; c < 40 && idx < 3; c++) begin
            tick;
            if (done8) begin
                tot = model8(opA[idx], opB[idx], opC[idx]);
                checkOutput("held_sum", {24'b0, sum8}, {24'b0, tot[7:0]});
                checkOutput("held_cout", {31'b0, cout8}, {31'b0, tot[8]});
                doneTimes[idx] = c;
                idx++;
                if (idx < 3)
                    applyStimulus(1'b0, opA[idx], opB[idx], opC[idx], 1'b1);
                else
                    start8 = 1'b0;
            end
        end
        start8 = 1'b0;
        checkOutput("held_count", 32'(idx), 32'd3);
        checkOutput("held_gap1", 32'(doneTimes[1] - doneTimes[0]), 32'd10);
        checkOutput("held_gap2", 32'(doneTimes[2] - doneTimes[1]), 32'd10);
        for (int k = 0; k < 12; k++) tick;

        $display("[TB] WIDTH=1 truth table");
        for (int i = 0; i < 8; i++)
            runOp(1'b1, {7'b0, 1'(i >> 2)}, {7'b0, 1'(i >> 1)}, 1'(i), 0, "w1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
